finger_thermo_encoder: RTL and testbench



---
 rtl/finger_thermo_encoder.sv | 109 ++++++++++
 tb/tb_finger_thermo_encoder.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/finger_thermo_encoder.sv
// Finger switch front end: synchronises and debounces N raw finger inputs,
// validates the settled pattern as an MSB-aligned thermometer code and encodes the count.
module finger_thermo_encoder #(
    parameter int N_FINGERS = 4,
    parameter int DEBOUNCE  = 4,
    parameter int WRAP      = 1,
    localparam int OUT_W    = $clog2(N_FINGERS + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_FINGERS-1:0] fingers_i,
    output logic [OUT_W-1:0]     code_o,
    output logic                 code_valid_o,
    output logic                 err_o,
    output logic                 busy_o
);

    localparam int CNT_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

    typedef enum logic {
        STABLE = 1'b0,
        SETTLE = 1'b1
    } state_t;

    state_t                 state, state_n;
    logic [N_FINGERS-1:0]   sync1, sync2;
    logic [N_FINGERS-1:0]   cand, cand_n;
    logic [N_FINGERS-1:0]   com, com_n;
    logic [CNT_W-1:0]       cnt, cnt_n;
    logic [OUT_W-1:0]       code_n;
    logic                   valid_n, err_n;
    logic [OUT_W-1:0]       k;
    logic [N_FINGERS-1:0]   therm;

    function automatic logic [OUT_W-1:0] count_ones(input logic [N_FINGERS-1:0] p);
        logic [OUT_W-1:0] c;
        c = '0;
        for (int i = 0; i < N_FINGERS; i++) begin
            c = c + OUT_W'(p[i]);
        end
        return c;
    endfunction

    // A legal code has exactly the top k bits set, so it must equal this mask.
    always_comb begin
        k     = count_ones(cand);
        therm = ~({N_FINGERS{1'b1}} >> k);
    end

    always_comb begin
        state_n = state;
        cand_n  = cand;
        cnt_n   = cnt;
        com_n   = com;
        code_n  = code_o;
        valid_n = 1'b0;
        err_n   = 1'b0;
        if (sync2 != cand) begin
            cand_n  = sync2;
            cnt_n   = '0;
            state_n = SETTLE;
        end else if (state == SETTLE) begin
            if (cnt == CNT_W'(DEBOUNCE - 1)) begin
                state_n = STABLE;
                if (cand == com) begin
                    com_n = com;
                end else if (cand == '0) begin
                    com_n = '0;
                end else if (cand == therm) begin
                    com_n   = cand;
                    code_n  = (WRAP != 0 && k == OUT_W'(N_FINGERS)) ? '0 : k;
                    valid_n = 1'b1;
                end else begin
                    com_n = cand;
                    err_n = 1'b1;
                end
            end else begin
                cnt_n = cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1        <= '0;
            sync2        <= '0;
            state        <= STABLE;
            cand         <= '0;
            cnt          <= '0;
            com          <= '0;
            code_o       <= '0;
            code_valid_o <= 1'b0;
            err_o        <= 1'b0;
        end else begin
            sync1        <= fingers_i;
            sync2        <= sync1;
            state        <= state_n;
            cand         <= cand_n;
            cnt          <= cnt_n;
            com          <= com_n;
            code_o       <= code_n;
            code_valid_o <= valid_n;
            err_o        <= err_n;
        end
    end

    assign busy_o = (state == SETTLE);

endmodule

// File: tb/tb_finger_thermo_encoder.sv
// Bench for finger_thermo_encoder: a legacy 4-finger instance and a 6-finger,
// no-wrap, single-cycle-debounce instance checked against expected strobe queues.
module tb_finger_thermo_encoder;

    localparam int D0 = 4;
    localparam int D1 = 1;
    localparam int W  = 24;

    logic       clk = 1'b0;
    logic       rst0, rst1;
    logic [3:0] fingers0;
    logic [5:0] fingers1;
    logic [2:0] code0, code1;
    logic       valid0, valid1, err0, err1, busy0, busy1;

    int checks = 0;
    int errors = 0;
    logic [19:0] cyc = '0;
    // Each entry: {edge count at which the strobe is seen, err flag, code}.
    logic [W-1:0] exp0_q[$];
    logic [W-1:0] exp1_q[$];

    always #5 clk = ~clk;

    finger_thermo_encoder #(.N_FINGERS(4), .DEBOUNCE(D0), .WRAP(1)) dut0 (
        .clk(clk), .rst(rst0), .fingers_i(fingers0),
        .code_o(code0), .code_valid_o(valid0), .err_o(err0), .busy_o(busy0)
    );

    finger_thermo_encoder #(.N_FINGERS(6), .DEBOUNCE(D1), .WRAP(0)) dut1 (
        .clk(clk), .rst(rst1), .fingers_i(fingers1),
        .code_o(code1), .code_valid_o(valid1), .err_o(err1), .busy_o(busy1)
    );

    task automatic expect0(input logic e, input logic [2:0] c);
        exp0_q.push_back({cyc + 20'(D0 + 3), e, c});
    endtask

    task automatic expect1(input logic e, input logic [2:0] c);
        exp1_q.push_back({cyc + 20'(D1 + 3), e, c});
    endtask

    // Advance one clock and compare any strobes against the expected queues.
    task automatic step();
        logic [W-1:0] e;
        @(posedge clk);
        cyc = cyc + 20'd1;
        @(negedge clk);
        if (valid0 && err0) begin
            checks++; errors++;
            $display("FAIL dut0_exclusive cyc=%0d valid=1 err=1 required not both", cyc);
        end
        if (valid0 || err0) begin
            checks++;
            if (exp0_q.size() == 0) begin
                errors++;
                $display("FAIL dut0_unexpected cyc=%0d valid=%0b err=%0b code=%0d required no strobe",
                         cyc, valid0, err0, code0);
            end else begin
                e = exp0_q.pop_front();
                if (cyc !== e[23:4] || err0 !== e[3] || valid0 !== ~e[3] || code0 !== e[2:0]) begin
                    errors++;
                    $display("FAIL dut0_strobe cyc=%0d err=%0b code=%0d required cyc=%0d err=%0b code=%0d",
                             cyc, err0, code0, e[23:4], e[3], e[2:0]);
                end
            end
        end else if (exp0_q.size() != 0 && exp0_q[0][23:4] <= cyc) begin
            checks++; errors++;
            e = exp0_q.pop_front();
            $display("FAIL dut0_missing cyc=%0d no strobe required err=%0b code=%0d at cyc=%0d",
                     cyc, e[3], e[2:0], e[23:4]);
        end
        if (valid1 && err1) begin
            checks++; errors++;
            $display("FAIL dut1_exclusive cyc=%0d valid=1 err=1 required not both", cyc);
        end
        if (valid1 || err1) begin
            checks++;
            if (exp1_q.size() == 0) begin
                errors++;
                $display("FAIL dut1_unexpected cyc=%0d valid=%0b err=%0b code=%0d required no strobe",
                         cyc, valid1, err1, code1);
            end else begin
                e = exp1_q.pop_front();
                if (cyc !== e[23:4] || err1 !== e[3] || valid1 !== ~e[3] || code1 !== e[2:0]) begin
                    errors++;
                    $display("FAIL dut1_strobe cyc=%0d err=%0b code=%0d required cyc=%0d err=%0b code=%0d",
                             cyc, err1, code1, e[23:4], e[3], e[2:0]);
                end
            end
        end else if (exp1_q.size() != 0 && exp1_q[0][23:4] <= cyc) begin
            checks++; errors++;
            e = exp1_q.pop_front();
            $display("FAIL dut1_missing cyc=%0d no strobe required err=%0b code=%0d at cyc=%0d",
                     cyc, e[3], e[2:0], e[23:4]);
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check_code0(input string name, input logic [2:0] c);
        checks++;
        if (code0 !== c) begin
            errors++;
            $display("FAIL %s code0=%0d required %0d", name, code0, c);
        end
    endtask

    task automatic test_reset();
        rst0 = 1'b1; rst1 = 1'b1; fingers0 = 4'b0000; fingers1 = '0;
        for (int i = 0; i < 8; i++) begin
            fingers0 = (i % 2 == 0) ? 4'b1111 : 4'b0000;
            step();
            checks++;
            if ({code0, valid0, err0, busy0} !== 6'b0 || {code1, valid1, err1, busy1} !== 6'b0) begin
                errors++;
                $display("FAIL reset_outputs code0=%0d v=%0b e=%0b b=%0b code1=%0d v=%0b e=%0b b=%0b required all 0",
                         code0, valid0, err0, busy0, code1, valid1, err1, busy1);
            end
        end
        fingers0 = 4'b1111;
        rst0 = 1'b0; rst1 = 1'b0;
        expect0(1'b0, 3'd0);
        steps(10);
    endtask

    task automatic test_legacy_map();
        logic [3:0] pats [4];
        logic [2:0] codes[4];
        pats  = '{4'b1000, 4'b1100, 4'b1110, 4'b1111};
        codes = '{3'd1, 3'd2, 3'd3, 3'd0};
        for (int i = 0; i < 4; i++) begin
            fingers0 = pats[i];
            expect0(1'b0, codes[i]);
            steps(10);
            check_code0("legacy_code_hold", codes[i]);
        end
    endtask

    task automatic test_bounce();
        int elapsed = 0;
        for (int ph = 0; ph < 6; ph++) begin
            fingers0 = (ph % 2 == 0) ? 4'b1000 : 4'b0000;
            for (int j = 0; j < 2; j++) begin
                step();
                elapsed++;
                if (elapsed >= 3) begin
                    checks++;
                    if (busy0 !== 1'b1) begin
                        errors++;
                        $display("FAIL bounce_busy cyc=%0d busy=%0b required 1", cyc, busy0);
                    end
                end
            end
        end
        fingers0 = 4'b1100;
        expect0(1'b0, 3'd2);
        steps(10);
        checks++;
        if (busy0 !== 1'b0) begin
            errors++;
            $display("FAIL bounce_idle busy=%0b required 0", busy0);
        end
        check_code0("bounce_code", 3'd2);
    endtask

    task automatic test_illegal();
        fingers0 = 4'b1010;
        expect0(1'b1, 3'd2);
        steps(10);
        fingers0 = 4'b0101;
        expect0(1'b1, 3'd2);
        steps(10);
        check_code0("illegal_code_held", 3'd2);
    endtask

    task automatic test_zero();
        fingers0 = 4'b1100;
        expect0(1'b0, 3'd2);
        steps(10);
        fingers0 = 4'b0000;
        steps(2);
        fingers0 = 4'b1100;
        steps(10);
        fingers0 = 4'b0000;
        steps(10);
        check_code0("zero_code_held", 3'd2);
        fingers0 = 4'b1100;
        expect0(1'b0, 3'd2);
        steps(10);
        check_code0("zero_recommit", 3'd2);
    endtask

    task automatic test_n6();
        fingers1 = 6'b111111;
        expect1(1'b0, 3'd6);
        steps(6);
        checks++;
        if (code1 !== 3'd6) begin
            errors++;
            $display("FAIL n6_full_code code1=%0d required 6", code1);
        end
        fingers1 = 6'b110000;
        steps(3);
        checks++;
        if (busy1 !== 1'b1) begin
            errors++;
            $display("FAIL n6_settle busy1=%0b required 1", busy1);
        end
        rst1 = 1'b1;
        #1;
        checks++;
        if ({code1, valid1, err1, busy1} !== 6'b0) begin
            errors++;
            $display("FAIL n6_async_clear code1=%0d v=%0b e=%0b b=%0b required all 0",
                     code1, valid1, err1, busy1);
        end
        steps(3);
        rst1 = 1'b0;
        expect1(1'b0, 3'd2);
        steps(8);
        checks++;
        if (code1 !== 3'd2) begin
            errors++;
            $display("FAIL n6_after_reset code1=%0d required 2", code1);
        end
    endtask

    initial begin
        test_reset();
        test_legacy_map();
        test_bounce();
        test_illegal();
        test_zero();
        test_n6();
        checks++;
        if (exp0_q.size() != 0 || exp1_q.size() != 0) begin
            errors++;
            $display("FAIL queues_drained left0=%0d left1=%0d required 0", exp0_q.size(), exp1_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
